// File: rtl/reg_read_arbiter_pkg.sv
// Shared CPU constants for the register read path: register file geometry,
// the fixed requester indices, and a small helper for round-robin arithmetic.
package reg_read_arbiter_pkg;

    localparam int REG_DATA_W = 16;
    localparam int REG_SEL_W  = 4;

    // Requester slots on the shared register read mux.
    localparam int REQ_ALU_A = 0;
    localparam int REQ_ALU_B = 1;
    localparam int REQ_PEEK  = 2;

    // Slot reached by stepping 'offset' places after 'base' in a ring of 'n'.
    function automatic int rr_slot(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/reg_read_arbiter_rr_pick.sv
// Combinational round-robin priority picker: the search starts one slot after
// ptr and wraps, so the most recent winner has the lowest priority.
module reg_read_arbiter_rr_pick
    import reg_read_arbiter_pkg::*;
#(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // First set request bit after ptr wins; gnt is one-hot or zero.
    always_comb begin
        int           slot;
        logic [N-1:0] shifted;
        // NOTE: every output and temporary gets a default before the search,
        // so no path leaves a value unassigned and no latch is inferred.
        gnt     = '0;
        idx     = '0;
        any     = 1'b0;
        slot    = 0;
        shifted = '0;
        for (int k = 1; k <= N; k++) begin
            slot    = rr_slot(int'(ptr), k, N);
            shifted = req >> slot;
            if (!any && shifted[0]) begin
                any = 1'b1;
                idx = IDX_W'(slot);
                gnt = N'(1) << slot;
            end
        end
    end

endmodule

// File: rtl/reg_read_arbiter.sv
// Shares the 16:1 register-select read mux between the ALU operand ports and
// the register-peek port. Round-robin issue stage drives mux_sel; the response
// stage captures mux_data one cycle later and holds it under backpressure.
module reg_read_arbiter
    import reg_read_arbiter_pkg::*;
#(
    parameter int N_REQ  = REQ_PEEK + 1,
    parameter int DATA_W = REG_DATA_W,
    parameter int SEL_W  = REG_SEL_W,
    parameter int ID_W   = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*SEL_W-1:0] req_addr,
    output logic [N_REQ-1:0]       req_ready,
    output logic [SEL_W-1:0]       mux_sel,
    input  logic [DATA_W-1:0]      mux_data,
    output logic                   resp_valid,
    output logic [DATA_W-1:0]      resp_data,
    output logic [ID_W-1:0]        resp_id,
    input  logic                   resp_ready
);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("reg_read_arbiter: N_REQ must be in 2..8");
    end
    if (ID_W < $clog2(N_REQ)) begin : g_bad_id_w
        $error("reg_read_arbiter: ID_W too small to index N_REQ requesters");
    end

    logic              issue_v;
    logic [ID_W-1:0]   issue_id;
    logic [ID_W-1:0]   rr_ptr;

    logic [N_REQ-1:0]  pick_gnt;
    logic [ID_W-1:0]   pick_idx;
    logic              pick_any;

    logic              resp_free;
    logic              issue_adv;
    logic              issue_free;
    logic              grant;
    logic [SEL_W-1:0]  grant_addr;

    // A stage can accept new work when it is empty or is handing off this cycle.
    assign resp_free  = !resp_valid || resp_ready;
    assign issue_adv  = issue_v && resp_free;
    assign issue_free = !issue_v || issue_adv;

    reg_read_arbiter_rr_pick #(
        .N     (N_REQ),
        .IDX_W (ID_W)
    ) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Ready is held low during reset so nothing looks granted while the
    // pipeline is being cleared.
    assign grant     = pick_any && issue_free && reset_n;
    assign req_ready = grant ? pick_gnt : '0;

    // Select the winner's register index out of the flattened address bus.
    always_comb begin
        grant_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == ID_W'(i)) begin
                grant_addr = req_addr[i*SEL_W +: SEL_W];
            end
        end
    end

    // Issue stage: latch the winner's select and id, advance the rr pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mux_sel  <= '0;
            issue_v  <= 1'b0;
            issue_id <= '0;
            rr_ptr   <= ID_W'(N_REQ - 1);
        end else if (grant) begin
            // NOTE: non-blocking assignments keep every register in this
            // pipeline updating from the same pre-edge values.
            mux_sel  <= grant_addr;
            issue_id <= pick_idx;
            issue_v  <= 1'b1;
            rr_ptr   <= pick_idx;
        end else if (issue_adv) begin
            issue_v  <= 1'b0;
        end
    end

    // Response stage: capture mux data at the end of the issue cycle and hold
    // it until the consumer takes it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= '0;
        end else if (issue_adv) begin
            resp_valid <= 1'b1;
            resp_data  <= mux_data;
            resp_id    <= issue_id;
        end else if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_read_arbiter.sv
// Directed bench for reg_read_arbiter: stimulus pushes each expected response
// into a scoreboard queue; a negedge monitor pops and compares whenever a
// response is handed off.
module tb_reg_read_arbiter;
    import reg_read_arbiter_pkg::*;

    localparam int N_REQ  = 3;
    localparam int DATA_W = 16;
    localparam int SEL_W  = 4;
    localparam int ID_W   = 2;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*SEL_W-1:0] req_addr;
    logic [N_REQ-1:0]       req_ready;
    logic [SEL_W-1:0]       mux_sel;
    logic [DATA_W-1:0]      mux_data;
    logic                   resp_valid;
    logic [DATA_W-1:0]      resp_data;
    logic [ID_W-1:0]        resp_id;
    logic                   resp_ready;

    // Register file model behind the mux.
    logic [DATA_W-1:0] regs [16];
    assign mux_data = regs[mux_sel];

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_pushed = 0;
    int   n_popped = 0;
    int   rem [N_REQ];

    reg_read_arbiter #(
        .N_REQ  (N_REQ),
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W),
        .ID_W   (ID_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .mux_sel    (mux_sel),
        .mux_data   (mux_data),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .resp_ready (resp_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a response transfers on the next rising edge when valid & ready.
    always @(negedge clk) begin
        if (reset_n && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                check("resp_unexpected", 32'(resp_id), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                n_popped++;
                check("resp_data", 32'(resp_data), 32'(e.data));
                check("resp_id", 32'(resp_id), 32'(e.id));
            end
        end
    end

    // Requester protocol: a pending request keeps valid and address until granted.
    logic [N_REQ-1:0]       prev_pending;
    logic [N_REQ*SEL_W-1:0] prev_addr;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_pending <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (prev_pending[i]) begin
                    assert (req_valid[i] && req_addr[i*SEL_W +: SEL_W] == prev_addr[i*SEL_W +: SEL_W])
                    else $error("requester %0d changed its request before grant", i);
                end
            end
            prev_pending <= req_valid & ~req_ready;
            prev_addr    <= req_addr;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    // One cycle in which requester 'id' must be the sole grant; optionally
    // records the response it must produce. Granted requesters retire one
    // request and drop valid after their last one.
    task automatic grant_cycle(input int id, input logic [DATA_W-1:0] data, input bit track);
        logic [N_REQ-1:0] g;
        exp_t             e;
        #1;
        g = req_ready;
        check("grant_onehot", 32'(g), 32'(1) << id);
        if (track) begin
            e.id   = ID_W'(id);
            e.data = data;
            sb.push_back(e);
            n_pushed++;
        end
        step();
        for (int i = 0; i < N_REQ; i++) begin
            if (g[i]) begin
                rem[i]--;
                if (rem[i] <= 0) req_valid[i] = 1'b0;
            end
        end
    endtask

    // One cycle with both stages full and the consumer stalled.
    task automatic stall_cycle(input logic [DATA_W-1:0] data, input int id, input int sel);
        #1;
        check("stall_req_ready", 32'(req_ready), 32'd0);
        check("stall_resp_valid", 32'(resp_valid), 32'd1);
        check("stall_resp_data", 32'(resp_data), 32'(data));
        check("stall_resp_id", 32'(resp_id), 32'(id));
        check("stall_mux_sel", 32'(mux_sel), 32'(sel));
        step();
    endtask

    initial begin
        int               req_t;
        int               g0_cnt;
        int               g2_cnt;
        logic [N_REQ-1:0] g;
        exp_t             e;

        reset_n    = 1'b0;
        req_valid  = 3'b001;
        req_addr   = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < 16; i++) regs[i] = '0;

        // Reset state, with a request already pending.
        #2;
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_mux_sel", 32'(mux_sel), 32'd0);
        check("rst_resp_data", 32'(resp_data), 32'd0);
        check("rst_resp_id", 32'(resp_id), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        step();
        reset_n = 1'b1;

        // Single request: r5 = BEEF via requester 0.
        regs[5]    = 16'hBEEF;
        req_addr   = {4'd0, 4'd0, 4'd5};
        rem        = '{1, 0, 0};
        resp_ready = 1'b1;
        grant_cycle(0, 16'hBEEF, 1'b1);
        check("single_mux_sel", 32'(mux_sel), 32'd5);
        check("single_resp_early", 32'(resp_valid), 32'd0);
        step();
        check("single_resp_valid", 32'(resp_valid), 32'd1);
        check("single_resp_data", 32'(resp_data), 32'hBEEF);
        check("single_resp_id", 32'(resp_id), 32'd0);
        step();
        check("single_resp_done", 32'(resp_valid), 32'd0);

        // All three requesting: rotation 0,1,2,0,1,2 with no bubbles.
        req_valid = '0;
        do_reset();
        regs[1]    = 16'h1111;
        regs[2]    = 16'h2222;
        regs[3]    = 16'h3333;
        req_addr   = {4'd3, 4'd2, 4'd1};
        rem        = '{2, 2, 2};
        req_valid  = 3'b111;
        resp_ready = 1'b1;
        grant_cycle(0, 16'h1111, 1'b1);
        grant_cycle(1, 16'h2222, 1'b1);
        check("stream_no_bubble", 32'(resp_valid), 32'd1);
        grant_cycle(2, 16'h3333, 1'b1);
        check("stream_no_bubble", 32'(resp_valid), 32'd1);
        grant_cycle(0, 16'h1111, 1'b1);
        check("stream_no_bubble", 32'(resp_valid), 32'd1);
        grant_cycle(1, 16'h2222, 1'b1);
        check("stream_no_bubble", 32'(resp_valid), 32'd1);
        grant_cycle(2, 16'h3333, 1'b1);
        check("stream_tail", 32'(resp_valid), 32'd1);
        step();
        check("stream_tail", 32'(resp_valid), 32'd1);
        step();
        check("stream_drained", 32'(resp_valid), 32'd0);

        // Backpressure: two grants fill the pipe, four stalled cycles, resume.
        rem        = '{2, 1, 1};
        req_valid  = 3'b111;
        resp_ready = 1'b1;
        grant_cycle(0, 16'h1111, 1'b1);
        grant_cycle(1, 16'h2222, 1'b1);
        resp_ready = 1'b0;
        repeat (4) stall_cycle(16'h1111, 0, 2);
        resp_ready = 1'b1;
        grant_cycle(2, 16'h3333, 1'b1);
        grant_cycle(0, 16'h1111, 1'b1);
        step();
        step();
        check("bp_drained", 32'(resp_valid), 32'd0);

        // Write after capture: r7 changes while the response is held.
        regs[7]    = 16'h0001;
        req_addr   = {4'd3, 4'd7, 4'd1};
        rem        = '{0, 1, 0};
        resp_ready = 1'b0;
        req_valid  = 3'b010;
        grant_cycle(1, 16'h0001, 1'b1);
        step();
        regs[7] = 16'h0002;
        repeat (3) stall_cycle(16'h0001, 1, 7);
        resp_ready = 1'b1;
        #1;
        check("wac_resp_data", 32'(resp_data), 32'h0001);
        step();
        check("wac_consumed", 32'(resp_valid), 32'd0);

        // Reset with both stages full, then requester 0 wins first.
        req_addr   = {4'd3, 4'd2, 4'd1};
        rem        = '{2, 1, 2};
        resp_ready = 1'b0;
        req_valid  = 3'b111;
        grant_cycle(2, 16'h3333, 1'b0);
        grant_cycle(0, 16'h1111, 1'b0);
        #1;
        check("full_no_grant", 32'(req_ready), 32'd0);
        check("full_resp_valid", 32'(resp_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("async_rst_mux_sel", 32'(mux_sel), 32'd0);
        check("async_rst_resp_data", 32'(resp_data), 32'd0);
        check("async_rst_req_ready", 32'(req_ready), 32'd0);
        step();
        reset_n    = 1'b1;
        resp_ready = 1'b1;
        grant_cycle(0, 16'h1111, 1'b1);
        grant_cycle(1, 16'h2222, 1'b1);
        grant_cycle(2, 16'h3333, 1'b1);
        step();
        step();
        check("rst_restart_drained", 32'(resp_valid), 32'd0);

        // Fairness: requester 2 continuous, requester 0 pulses every 3 cycles.
        regs[4]    = 16'h4444;
        regs[6]    = 16'h6666;
        req_addr   = {4'd6, 4'd0, 4'd4};
        req_valid  = 3'b100;
        resp_ready = 1'b1;
        req_t      = 0;
        g0_cnt     = 0;
        g2_cnt     = 0;
        for (int cyc = 0; cyc < 99; cyc++) begin
            if (cyc % 3 == 0) begin
                req_valid[0] = 1'b1;
                req_t        = cyc;
            end
            #1;
            g = req_ready;
            check("fair_some_grant", 32'(|g), 32'd1);
            if (g[0]) begin
                check("fair_req0_latency", 32'(cyc - req_t <= 1), 32'd1);
                e.id   = 2'd0;
                e.data = 16'h4444;
                sb.push_back(e);
                n_pushed++;
                g0_cnt++;
            end
            if (g[2]) begin
                e.id   = 2'd2;
                e.data = 16'h6666;
                sb.push_back(e);
                n_pushed++;
                g2_cnt++;
            end
            step();
            if (g[0]) req_valid[0] = 1'b0;
        end
        req_valid = '0;
        step();
        step();
        check("fair_req0_count", 32'(g0_cnt), 32'd33);
        check("fair_req2_count", 32'(g2_cnt), 32'd66);
        check("fair_drained", 32'(resp_valid), 32'd0);

        // Nothing lost, nothing duplicated.
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("resp_count", 32'(n_popped), 32'(n_pushed));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reg_read_arbiter.md
Name: reg_read_arbiter

Overview:
- Shares the single 16-bit, 16:1 register-select read mux between N_REQ requesters: ALU operand A, ALU operand B, and the game/VGA register-peek port.
- Round-robin arbitration with valid/ready handshakes on both sides.
- Two-stage pipeline: the issue stage drives the mux select, the response stage captures the mux data.
- Sits between the control unit and the register file.

Parameters:
N_REQ, 3, number of requesters (2..8)
DATA_W, 16, register data width
SEL_W, 4, register-select width (16 registers)
ID_W, 2, requester index width, must be >= clog2(N_REQ)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
req_valid  in  N_REQ  per-requester read request
req_addr  in  N_REQ*SEL_W  per-requester register index; slice i belongs to requester i
req_ready  out  N_REQ  one-hot grant; a transfer happens when req_valid[i] and req_ready[i] are both high
mux_sel  out  SEL_W  registered select to the 16:1 register mux
mux_data  in  DATA_W  combinational mux output
resp_valid  out  1  read data valid
resp_data  out  DATA_W  captured register value
resp_id  out  ID_W  index of the requester that owns resp_data
resp_ready  in  1  consumer accepts the response

Behaviour:
- Reset values (asynchronous, on reset_n low): mux_sel=0, issue_v=0, issue_id=0, resp_valid=0, resp_data=0, resp_id=0, rr_ptr=N_REQ-1. req_ready is combinational and is 0 while reset_n is low.
- Stage advance conditions:
  - resp_free = !resp_valid | resp_ready.
  - issue_adv = issue_v & resp_free.
  - issue_free = !issue_v | issue_adv.
- Grant (combinational):
  - Only when issue_free.
  - Search req_valid starting at (rr_ptr+1) mod N_REQ and wrapping; the first set bit wins.
  - req_ready is one-hot on the winner and all zero when nothing is valid or when issue_free=0.
  - req_ready never depends on any other requester's ready.
- On a grant edge:
  - mux_sel <= req_addr[winner].
  - issue_id <= winner, issue_v <= 1.
  - rr_ptr <= winner.
- With no grant: issue_v <= 0 if issue_adv, otherwise hold. mux_sel holds its value unless there is a new grant.
- Response stage on issue_adv:
  - resp_data <= mux_data.
  - resp_id <= issue_id.
  - resp_valid <= 1.
- When resp_valid & resp_ready and there is no issue_adv, resp_valid <= 0.
- Latency:
  - Grant at edge E0; resp_valid is high after edge E1.
  - Sustained throughput is 1 read per cycle while resp_ready=1.
- Backpressure:
  - While resp_valid=1 and resp_ready=0, resp_data, resp_id, mux_sel and issue_id are all frozen.
  - Once both stages are full, req_ready is 0.
- Stability rules:
  - resp_data reflects register contents at the end of the issue cycle. A register write after capture does not alter resp_data.
  - A requester must hold req_valid and req_addr stable until granted. The arbiter does not check this; the bench asserts it.
- Simultaneous events:
  - All requesters valid: grants rotate 0,1,2,0,...
  - A lone requester is granted every free cycle.
  - A response being consumed and a new grant in the same cycle is legal, with no bubble.
- Reset mid-operation: in-flight issue and response are dropped without completion, and arbitration restarts with requester 0 highest.
- Out-of-range requester index never occurs for N_REQ <= 2^ID_W. Elaboration fails if ID_W is too small.

Decomposition:
- Shared CPU package holds REG_DATA_W=16, REG_SEL_W=4, and the requester index constants REQ_ALU_A=0, REQ_ALU_B=1, REQ_PEEK=2.
- One sub-module: rr_pick, a combinational round-robin priority picker. Inputs: req vector and pointer. Outputs: one-hot grant, index, any.
- Pipeline registers stay in the top module.

Test Plan:
- Reset then single request: req_valid=001, addr0=5, mux model with r5=16'hBEEF, resp_ready=1 -> req_ready=001 at E0, mux_sel=5 after E0, resp_valid=1 / resp_data=BEEF / resp_id=0 after E1.
- All three requesting continuously, addrs 1/2/3 with r_n=n*16'h1111 -> grant order 0,1,2,0,1,2. Responses 1111, 2222, 3333 on consecutive cycles, with no bubbles.
- Backpressure: resp_ready=0 for 4 cycles during the stream -> resp_data and mux_sel stable, req_ready=000 after 2 grants. Resume with no lost or duplicated responses.
- Write after capture: r7 changes from 0x0001 to 0x0002 the cycle after capture -> resp_data stays 0x0001 until consumed.
- Reset asserted with both stages full -> resp_valid=0, mux_sel=0 immediately, asynchronously. After release, requester 0 wins first over 1 and 2.
- Fairness: requester 2 continuous, requester 0 pulsing every 3 cycles -> requester 0 is granted within 1 cycle of each request. Neither requester is starved over 100 cycles.
